// File: rtl/phase_demod_ctrl.sv
// phase_demod_ctrl: NRZ-M bit recovery from a hard-decision phase input,
// sync-word framing and a fixed-length payload writer into an external RAM.
module phase_demod_ctrl #(
  parameter int                    data_width   = 8,
  parameter int                    frame_length = 150,
  parameter int                    addr_width   = 8,
  parameter int                    ref_clk_freq = 128000000,
  parameter int                    baudrate     = 9600,
  parameter logic [data_width-1:0] sync_word    = 8'h7E
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  phase_in,
  output logic                  locked,
  output logic                  frame_done,
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wr_data,
  output logic                  ram_rst
);

  // One bit period spans CYCLE+1 clocks; the sample point sits mid-bit.
  localparam int CYCLE = ref_clk_freq / baudrate;
  localparam int CNT_W = (CYCLE > 0) ? $clog2(CYCLE + 1) : 1;
  localparam int BIT_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(CYCLE);
  localparam logic [CNT_W-1:0]      CNT_HALF = CNT_W'(CYCLE / 2);
  localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(data_width - 1);
  localparam logic [addr_width-1:0] ADDR_LAST = addr_width'(frame_length - 1);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_RECV, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  ph_meta_q, ph_s_q, ph_dly_q, prev_q;
  logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [data_width-1:0] sh_q, sh_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;

  logic                  edge_det;
  logic                  strobe;
  logic [data_width-1:0] sh_shift;

  // Edge detection, mid-bit strobe and the NRZ-M decoded shift value.
  always_comb begin
    edge_det = ph_s_q ^ ph_dly_q;
    strobe   = (state_q != S_IDLE) && !edge_det && (cycle_cnt_q == CNT_HALF);
    sh_shift = {sh_q[data_width-2:0], ph_s_q ^ prev_q};
  end

  // Next-state logic: bit timing, framing FSM, byte assembly and RAM writes.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = strobe ? sh_shift : sh_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;

    // An input edge realigns the bit clock and takes priority over the strobe.
    if (state_q == S_IDLE || edge_det || cycle_cnt_q == CNT_MAX) begin
      cycle_cnt_d = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end

    if (!rx_en) begin
      // Dropping the enable discards any partial byte and pending write.
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      sh_d      = '0;
      addr_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_HUNT;
          sh_d    = '0;
        end
        S_HUNT: begin
          if (strobe && sh_shift == sync_word) begin
            state_d   = S_RECV;
            bit_cnt_d = '0;
          end
        end
        S_RECV: begin
          if (strobe) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              wr_en_d   = 1'b1;
              wr_data_d = sh_shift;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          // Address advances once the current write has been presented.
          if (wr_en_q) begin
            if (addr_q == ADDR_LAST) begin
              addr_d  = '0;
              state_d = S_DONE;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Clearing sh forces the next sync word to be built from fresh bits.
          state_d = S_HUNT;
          sh_d    = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_meta_q   <= 1'b0;
      ph_s_q      <= 1'b0;
      ph_dly_q    <= 1'b0;
      prev_q      <= 1'b0;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_meta_q   <= phase_in;
      ph_s_q      <= ph_meta_q;
      ph_dly_q    <= ph_s_q;
      if (strobe) begin
        prev_q <= ph_s_q;
      end
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
    end
  end

  // Output mapping.
  always_comb begin
    locked      = (state_q == S_RECV);
    frame_done  = (state_q == S_DONE);
    ram_clk     = clk;
    ram_en      = wr_en_q;
    ram_we      = wr_en_q;
    ram_addr    = addr_q;
    ram_wr_data = wr_data_q;
    ram_rst     = 1'b0;
  end

endmodule

// File: tb/tb_phase_demod_ctrl.sv
// tb_phase_demod_ctrl: randomized NRZ-M frames against a frame-level model.
module tb_phase_demod_ctrl;
  localparam int DW  = 8;
  localparam int FL  = 3;
  localparam int AW  = 8;
  localparam int BIT = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_en = 1'b0;
  logic          phase_in = 1'b0;
  logic          locked, frame_done, ram_clk, ram_en, ram_we, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  phase_demod_ctrl #(
    .data_width(DW), .frame_length(FL), .addr_width(AW),
    .ref_clk_freq(16), .baudrate(1), .sync_word(8'h7E)
  ) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .phase_in(phase_in),
    .locked(locked), .frame_done(frame_done), .ram_clk(ram_clk),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rst(ram_rst)
  );

  // Monitor: RAM writes as {addr,data}, frame_done positions, locked cycles.
  logic [15:0] wr_q[$];
  int          done_at[$];
  int          locked_cnt = 0;
  always @(negedge clk) begin
    if (ram_en && ram_we) wr_q.push_back({ram_addr, ram_wr_data});
    if (frame_done) done_at.push_back(wr_q.size());
    if (locked) locked_cnt++;
  end

  // Stimulus: bit list, NRZ-M line level, per-edge jitter.
  bit bits_q[$];
  bit lvl = 1'b0;
  int jp  = 0;

  task automatic add_zeros(input int n);
    repeat (n) bits_q.push_back(1'b0);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
  endtask

  task automatic play(input bit jit);
    bit b;
    int jn;
    while (bits_q.size() > 0) begin
      b = bits_q.pop_front();
      @(posedge clk);
      #1;
      lvl = lvl ^ b;
      phase_in = lvl;
      jn = jit ? (int'($urandom_range(6)) - 3) : 0;
      repeat (BIT + jn - jp - 1) @(posedge clk);
      jp = jn;
    end
  endtask

  task automatic load_frame(input logic [23:0] p);
    add_zeros(4);
    add_byte(8'h7E);
    for (int i = 0; i < 3; i++) add_byte(p[8*(2-i) +: 8]);
    add_zeros(3);
  endtask

  // Model: payload byte i of a frame lands at address i mod frame_length.
  function automatic logic [15:0] exp_wr(input int idx, input logic [23:0] p);
    logic [7:0] a;
    a = 8'(idx % FL);
    return {a, p[8*(2-idx) +: 8]};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got %b want 0", locked); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", frame_done); end
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL rst_strobes got %b%b want 00", ram_en, ram_we); end
    total++; if (ram_addr !== '0) begin bad++; $display("FAIL rst_addr got %h want 00", ram_addr); end
    total++; if (ram_wr_data !== '0) begin bad++; $display("FAIL rst_data got %h want 00", ram_wr_data); end
    total++; if (ram_rst !== 1'b0) begin bad++; $display("FAIL ram_rst got %b want 0", ram_rst); end
    total++; if (ram_clk !== clk) begin bad++; $display("FAIL ram_clk got %b want %b", ram_clk, clk); end
    rst = 1'b0;
    rx_en = 1'b1;
    $display("reset checked");
  endtask

  // Plays one frame and checks writes, done pulse and lock against the model.
  task automatic check_frame(input string nm, input logic [23:0] p, input bit jit);
    int base, dbase, lbase;
    base = wr_q.size(); dbase = done_at.size(); lbase = locked_cnt;
    load_frame(p);
    play(jit);
    total++;
    if (wr_q.size() - base != 3) begin
      bad++; $display("FAIL %s_count got %0d want 3", nm, wr_q.size() - base);
    end
    for (int i = 0; i < 3 && base + i < wr_q.size(); i++) begin
      total++;
      if (wr_q[base+i] !== exp_wr(i, p)) begin
        bad++; $display("FAIL %s_wr%0d got %h want %h", nm, i, wr_q[base+i], exp_wr(i, p));
      end
    end
    total++;
    if (done_at.size() - dbase != 1 || (done_at.size() > dbase && done_at[dbase] != base + 3)) begin
      bad++; $display("FAIL %s_done pulses=%0d want 1 after write %0d", nm, done_at.size() - dbase, base + 3);
    end
    total++; if (locked_cnt == lbase) begin bad++; $display("FAIL %s_locked got never want seen", nm); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL %s_after got locked=%b want 0", nm, locked); end
    $display("frame %s payload=%h writes=%0d", nm, p, wr_q.size() - base);
  endtask

  task automatic test_basic();
    check_frame("basic", 24'h00FFA5, 1'b0);
  endtask

  task automatic test_constant();
    int base, lbase, dbase;
    base = wr_q.size(); lbase = locked_cnt; dbase = done_at.size();
    add_zeros(30);
    play(1'b0);
    total++; if (wr_q.size() != base) begin bad++; $display("FAIL const_writes got %0d want 0", wr_q.size() - base); end
    total++; if (locked_cnt != lbase) begin bad++; $display("FAIL const_locked got %0d cycles want 0", locked_cnt - lbase); end
    total++; if (done_at.size() != dbase) begin bad++; $display("FAIL const_done got %0d want 0", done_at.size() - dbase); end
    $display("constant phase: writes=%0d", wr_q.size() - base);
  endtask

  task automatic test_skew();
    check_frame("skew", 24'h00FFA5, 1'b1);
  endtask

  task automatic test_sync_in_payload();
    check_frame("syncdata", 24'h117E22, 1'b1);
  endtask

  task automatic test_random();
    logic [23:0] p;
    for (int f = 0; f < 4; f++) begin
      p = 24'($urandom);
      check_frame("rand", p, 1'b1);
    end
  endtask

  task automatic test_abort();
    int base;
    logic [7:0] b2;
    base = wr_q.size();
    b2 = 8'hC3;
    add_zeros(4); add_byte(8'h7E); add_byte(8'h3C); add_byte(8'h81);
    for (int i = 7; i >= 5; i--) bits_q.push_back(b2[i]);
    play(1'b0);
    total++; if (wr_q.size() - base != 2) begin bad++; $display("FAIL abort_pre got %0d want 2", wr_q.size() - base); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL abort_lock got %b want 1", locked); end
    @(posedge clk); #1 rx_en = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL abort_idle got locked=%b want 0", locked); end
    total++; if (ram_addr !== '0) begin bad++; $display("FAIL abort_addr got %h want 00", ram_addr); end
    for (int i = 4; i >= 0; i--) bits_q.push_back(b2[i]);
    add_zeros(4);
    play(1'b0);
    total++; if (wr_q.size() - base != 2) begin bad++; $display("FAIL abort_post got %0d want 2", wr_q.size() - base); end
    $display("abort: writes=%0d", wr_q.size() - base);
    rx_en = 1'b1;
    check_frame("after_abort", 24'hDEAD42, 1'b1);
  endtask

  task automatic test_rst_midbyte();
    int base;
    base = wr_q.size();
    add_zeros(4); add_byte(8'h7E); add_byte(8'h5A);
    bits_q.push_back(1'b1); bits_q.push_back(1'b1); bits_q.push_back(1'b0); bits_q.push_back(1'b0);
    play(1'b0);
    total++; if (wr_q.size() - base != 1) begin bad++; $display("FAIL rstmid_pre got %0d want 1", wr_q.size() - base); end
    #3 rst = 1'b1;
    #1;
    total++; if (locked !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_state got locked=%b done=%b want 0 0", locked, frame_done); end
    total++; if (ram_addr !== '0 || ram_wr_data !== '0) begin bad++; $display("FAIL rstmid_addr got %h/%h want 00/00", ram_addr, ram_wr_data); end
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rstmid_en got %b want 0", ram_en); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    bits_q.push_back(1'b0); bits_q.push_back(1'b0); bits_q.push_back(1'b1); bits_q.push_back(1'b1);
    add_zeros(4);
    play(1'b0);
    total++; if (wr_q.size() - base != 1) begin bad++; $display("FAIL rstmid_post got %0d want 1", wr_q.size() - base); end
    $display("reset mid-byte: writes=%0d", wr_q.size() - base);
    check_frame("after_rst", 24'h7E0099, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_constant();
    test_skew();
    test_sync_in_payload();
    test_random();
    test_abort();
    test_rst_midbyte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
